// File: rtl/fmap_pkg.sv
// fmap_pkg: shared error bit indices, side type and counter width helper for fmap_pingpong
package fmap_pkg;
  localparam int ERR_DROP  = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_SHORT = 2;
  typedef logic side_t;
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/fmap_bank.sv
// fmap_bank: one dual-port bank of 2*DEPTH words (ping side then pong side), registered read
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/side/addr/data write strobe (already gated by ownership), side, address, data
//   rd_en/side/addr      read strobe (already gated by ownership), side, address
//   rd_data, rd_valid    registered read result, latency 1
//   wr_range, rd_range   strobe with address >= DEPTH this cycle
module fmap_bank import fmap_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 196
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  side_t                 wr_side,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  side_t                 rd_side,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_range,
  output logic                  rd_range
);
  localparam int MW = $clog2(2 * DEPTH);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [2 * DEPTH];
  logic [MW-1:0] wr_idx, rd_idx;
  // Sides are packed back to back so only 2*DEPTH words are stored; the range
  // check is what keeps an out-of-range address from aliasing into the other side.
  assign wr_idx   = wr_side ? MW'(DEPTH) + MW'(wr_addr) : MW'(wr_addr);
  assign rd_idx   = rd_side ? MW'(DEPTH) + MW'(rd_addr) : MW'(rd_addr);
  assign wr_range = wr_en & ({1'b0, wr_addr} >= LIM);
  assign rd_range = rd_en & ({1'b0, rd_addr} >= LIM);
  always_ff @(posedge clk)
    if (wr_en && !wr_range) mem[wr_idx] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_range ? '0 : mem[rd_idx];
    end
endmodule

// File: rtl/fmap_pingpong.sv
// fmap_pingpong: double-buffered multi-bank feature-map store with done/release side handover
//   clk, rst                    clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data     packed per-bank write port; wr_done closes the write side
//   wr_ready                    write side owned by the producer
//   rd_en, rd_addr              packed per-bank read port; rd_release frees the read side
//   rd_data, rd_valid           packed per-bank registered read result
//   rd_ready                    read side holds a complete layer
//   wr_side, rd_side            side currently targeted by writes / reads
//   err                         sticky: [0] dropped write/done, [1] address >= DEPTH, [2] short fill
// Optional macro FMAP_FILL_CHECK_EN enables the per-bank fill counters behind err[2].
module fmap_pingpong import fmap_pkg::*; #(
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 196
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BANKS-1:0]            wr_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wr_data,
  input  logic                            wr_done,
  output logic                            wr_ready,
  input  logic [NUM_BANKS-1:0]            rd_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_BANKS-1:0]            rd_valid,
  input  logic                            rd_release,
  output logic                            rd_ready,
  output logic                            wr_side,
  output logic                            rd_side,
  output logic [2:0]                      err
);
  logic [1:0] full, full_n;
  logic [NUM_BANKS-1:0] wr_range, rd_range;
  logic wr_acc, rel, short_fill;
  assign wr_ready = !full[wr_side];
  assign rd_ready = full[rd_side];
  assign wr_acc   = wr_done & wr_ready;
  assign rel      = rd_release & rd_ready;
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    fmap_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[g] & wr_ready),
      .wr_side  (wr_side),
      .wr_addr  (wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_data  (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en    (rd_en[g] & rd_ready),
      .rd_side  (rd_side),
      .rd_addr  (rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .rd_data  (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (rd_valid[g]),
      .wr_range (wr_range[g]),
      .rd_range (rd_range[g])
    );
  end
  // Release and done always target different sides when both are accepted,
  // since ownership requires full[rd_side]=1 and full[wr_side]=0.
  always_comb begin
    full_n = full;
    if (rel) full_n[rd_side] = 1'b0;
    if (wr_acc) full_n[wr_side] = 1'b1;
  end
`ifdef FMAP_FILL_CHECK_EN
  localparam int CW = cnt_width(ADDR_WIDTH);
  logic [NUM_BANKS-1:0] bad;
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_cnt
    logic [CW-1:0] cnt;
    logic ok;
    assign ok = wr_en[g] & wr_ready & !wr_range[g];
    // Writes landing in the same cycle as wr_done still belong to the closing side.
    assign bad[g] = (cnt + CW'(ok)) != CW'(DEPTH);
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= wr_acc ? '0 : cnt + CW'(ok);
  end
  assign short_fill = wr_acc & |bad;
`else
  assign short_fill = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full    <= 2'b00;
      wr_side <= 1'b0;
      rd_side <= 1'b0;
      err     <= 3'b000;
    end else begin
      full             <= full_n;
      wr_side          <= wr_side ^ wr_acc;
      rd_side          <= rd_side ^ rel;
      err[ERR_DROP]    <= err[ERR_DROP] | ((|wr_en | wr_done) & !wr_ready);
      err[ERR_RANGE]   <= err[ERR_RANGE] | |wr_range | |rd_range;
      err[ERR_SHORT]   <= err[ERR_SHORT] | short_fill;
    end
endmodule

// File: tb/tb_fmap_pingpong.sv
// tb_fmap_pingpong: directed self-checking bench for fmap_pingpong
module tb_fmap_pingpong;
  localparam int NB = 16, AW = 8, DW = 16, DEPTH = 196;
`ifdef FMAP_FILL_CHECK_EN
  localparam logic SHORT_EXP = 1'b1;
`else
  localparam logic SHORT_EXP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [NB-1:0] wr_en, rd_en, rd_valid;
  logic [NB*AW-1:0] wr_addr, rd_addr;
  logic [NB*DW-1:0] wr_data, rd_data, exp_data;
  logic wr_done, wr_ready, rd_release, rd_ready, wr_side, rd_side;
  logic [2:0] err;
  int tests = 0, fails = 0;

  fmap_pingpong #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_release(rd_release), .rd_ready(rd_ready),
    .wr_side(wr_side), .rd_side(rd_side), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = '0; rd_en = '0; wr_done = 1'b0; rd_release = 1'b0;
  endtask

  task automatic set_all(input int a, input int d);
    for (int i = 0; i < NB; i++) begin
      wr_addr[i*AW +: AW] = AW'(a);
      rd_addr[i*AW +: AW] = AW'(a);
      wr_data[i*DW +: DW] = DW'(d);
    end
  endtask

  task automatic do_reset;
    idle();
    set_all(0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (rd_valid !== '0) begin fails++; $display("FAIL reset_rd_valid got %h want 0", rd_valid); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    tests++; if (err !== 3'b000) begin fails++; $display("FAIL reset_err got %b want 000", err); end
    tests++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got wr=%b rd=%b want wr=1 rd=0", wr_ready, rd_ready); end
    tests++; if (wr_side !== 1'b0 || rd_side !== 1'b0) begin fails++; $display("FAIL reset_sides got wr=%b rd=%b want 0 0", wr_side, rd_side); end
  endtask

  task automatic test_basic;
    do_reset();
    wr_en = 16'h0008; wr_addr[3*AW +: AW] = 8'd5; wr_data[3*DW +: DW] = 16'h1234;
    tick();
    wr_en = '0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0; rd_en = 16'h0008; rd_addr[3*AW +: AW] = 8'd5;
    tick();
    tests++; if (rd_data[3*DW +: DW] !== 16'h1234) begin fails++; $display("FAIL basic_data got %h want 1234", rd_data[3*DW +: DW]); end
    tests++; if (rd_valid !== 16'h0008) begin fails++; $display("FAIL basic_valid got %h want 0008", rd_valid); end
    tests++; if (rd_side !== 1'b0 || wr_side !== 1'b1) begin fails++; $display("FAIL basic_sides got rd=%b wr=%b want rd=0 wr=1", rd_side, wr_side); end
    rd_en = '0;
    tick();
    tests++; if (rd_valid !== '0 || rd_data[3*DW +: DW] !== 16'h1234) begin fails++; $display("FAIL basic_hold got valid=%h data=%h want 0 1234", rd_valid, rd_data[3*DW +: DW]); end
  endtask

  task automatic test_fill_full;
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_all(a, a); wr_en = '1;
      tick();
    end
    wr_en = '0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      set_all(a, a + 'h100); wr_en = '1; rd_en = '1;
      tick();
      for (int i = 0; i < NB; i++) exp_data[i*DW +: DW] = DW'(a);
      tests++; if (rd_data !== exp_data || rd_valid !== '1) begin fails++; $display("FAIL fill_read addr=%0d got %h valid=%h want %h", a, rd_data, rd_valid, exp_data); end
    end
    idle(); wr_done = 1'b1;
    tick();
    idle();
    tests++; if (err !== 3'b000) begin fails++; $display("FAIL fill_no_err got %b want 000", err); end
    tests++; if (wr_ready !== 1'b0 || rd_ready !== 1'b1) begin fails++; $display("FAIL full_ready got wr=%b rd=%b want 0 1", wr_ready, rd_ready); end
    set_all(7, 'hdead); wr_en = 16'h0001;
    tick();
    idle();
    tests++; if (err !== 3'b001) begin fails++; $display("FAIL full_drop_err got %b want 001", err); end
    set_all(7, 0); rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_data[DW-1:0] !== 16'h0007) begin fails++; $display("FAIL full_mem_unchanged got %h want 0007", rd_data[DW-1:0]); end
    rd_release = 1'b1; rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_data[DW-1:0] !== 16'h0007) begin fails++; $display("FAIL release_old_side got %h want 0007", rd_data[DW-1:0]); end
    tests++; if (wr_ready !== 1'b1 || rd_side !== 1'b1) begin fails++; $display("FAIL release_ready got wr_ready=%b rd_side=%b want 1 1", wr_ready, rd_side); end
    rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_data[DW-1:0] !== 16'h0107) begin fails++; $display("FAIL release_new_side got %h want 0107", rd_data[DW-1:0]); end
  endtask

  task automatic test_swap;
    do_reset();
    set_all(3, 'h0aaa); wr_en = 16'h0001;
    tick();
    wr_en = '0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0; set_all(3, 'h0bbb); wr_en = 16'h0001;
    tick();
    wr_en = '0; wr_done = 1'b1; rd_release = 1'b1;
    tick();
    idle();
    tests++; if (rd_side !== 1'b1 || wr_side !== 1'b0) begin fails++; $display("FAIL swap_sides got rd=%b wr=%b want 1 0", rd_side, wr_side); end
    tests++; if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin fails++; $display("FAIL swap_ready got rd=%b wr=%b want 1 1", rd_ready, wr_ready); end
    tests++; if (err[1:0] !== 2'b00) begin fails++; $display("FAIL swap_err got %b want 00", err[1:0]); end
    rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_data[DW-1:0] !== 16'h0bbb) begin fails++; $display("FAIL swap_read got %h want 0bbb", rd_data[DW-1:0]); end
  endtask

  task automatic test_range;
    do_reset();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0; set_all(4, 'h4444); wr_en = 16'h0001;
    tick();
    wr_en = '0; wr_done = 1'b1;
    tick();
    idle(); rd_release = 1'b1;
    tick();
    idle(); set_all(200, 'hbeef); wr_en = 16'h0001;
    tick();
    idle();
    tests++; if (err[1:0] !== 2'b10) begin fails++; $display("FAIL range_wr_err got %b want 10", err[1:0]); end
    set_all(4, 0); rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_data[DW-1:0] !== 16'h4444) begin fails++; $display("FAIL range_no_alias got %h want 4444", rd_data[DW-1:0]); end
    set_all(200, 0); rd_en = 16'h0001;
    tick();
    idle();
    tests++; if (rd_valid[0] !== 1'b1 || rd_data[DW-1:0] !== '0) begin fails++; $display("FAIL range_rd got valid=%b data=%h want 1 0000", rd_valid[0], rd_data[DW-1:0]); end
    set_all(4, 0); rd_en = '1;
    tick();
    tests++; if (rd_valid !== '1) begin fails++; $display("FAIL pre_rst_valid got %h want ffff", rd_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (rd_valid !== '0 || rd_data !== '0) begin fails++; $display("FAIL midrst_rd got valid=%h data=%h want 0", rd_valid, rd_data); end
    tests++; if (err !== 3'b000 || rd_ready !== 1'b0 || wr_side !== 1'b0 || rd_side !== 1'b0) begin fails++; $display("FAIL midrst_ctrl got err=%b rd_ready=%b sides=%b%b want 000 0 00", err, rd_ready, wr_side, rd_side); end
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_check;
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_all(a, a); wr_en = (a == DEPTH - 1) ? 16'hff7f : 16'hffff;
      tick();
    end
    idle(); wr_done = 1'b1;
    tick();
    idle();
    tests++; if (err[2] !== SHORT_EXP) begin fails++; $display("FAIL short_fill_err got %b want %b", err[2], SHORT_EXP); end
    tests++; if (rd_ready !== 1'b1 || wr_side !== 1'b1) begin fails++; $display("FAIL short_fill_handover got rd_ready=%b wr_side=%b want 1 1", rd_ready, wr_side); end
  endtask

  initial begin
    idle();
    set_all(0, 0);
    test_reset();
    test_basic();
    test_fill_full();
    test_swap();
    test_range();
    test_fill_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
